// File: rtl/instr_decode_pkg.sv
// Shared types for the decode stage issue control.
package instr_decode;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } t_de_ctl_state;

endpackage

// File: rtl/instr_pkg.sv
// Fetched-instruction type shared by the front end and decode.
// Simulation builds carry a SIMID tag alongside the instruction bits.
package instr;

  typedef struct packed {
`ifdef SIMULATION
    logic [15:0] simid;
`endif
    logic [31:0] bits;
  } t_rv_instr;

endpackage

// File: rtl/de_iq_fifo.sv
// Instruction queue between fetch and decode: circular buffer with head
// read-out, occupancy count and a single-cycle clear.
module de_iq_fifo
  import instr::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  t_rv_instr                push_data,
  input  logic                     pop,
  input  logic                     clear,
  output t_rv_instr                head,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  t_rv_instr        mem_q [DEPTH];
  t_rv_instr        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head      = mem_q[rd_ptr_q];
  assign occupancy = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full))
        else $error("de_iq_fifo: push while full");
    end
  end
`endif

endmodule

// File: rtl/decode_issue_ctl.sv
// Decode issue control: queues fetched instructions and issues them to decode
// while read-stage credits are available, with a one-cycle flush bubble.
module decode_issue_ctl
  import instr::*;
  import instr_decode::*;
#(
  parameter int DEPTH      = 4,
  parameter int RD_CREDITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fe_valid,
  input  t_rv_instr                     fe_instr,
  output logic                          fe_ready,
  output logic                          valid_de0,
  output t_rv_instr                     instr_de0,
  input  logic                          rd_credit_ret,
  input  logic                          flush,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic [$clog2(RD_CREDITS):0]   credits
);

  localparam int OCC_W  = $clog2(DEPTH) + 1;
  localparam int CRED_W = $clog2(RD_CREDITS) + 1;

  t_de_ctl_state     state_q, state_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic              push;
  logic              issue;
  logic              fifo_full;
  t_rv_instr         head;

  de_iq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (fe_instr),
    .pop       (issue),
    .clear     (flush),
    .head      (head),
    .occupancy (occupancy),
    .full      (fifo_full)
  );

  // Reset and flush both suppress issue and enqueue in their own cycle.
  always_comb begin
    fe_ready  = !fifo_full && (state_q != FLUSH);
    push      = fe_valid && fe_ready && !flush && !reset;
    issue     = (state_q == RUN) && (occupancy != '0) && (credits_q != '0)
                && !flush && !reset;
    valid_de0 = issue;
    instr_de0 = issue ? head : '0;
  end

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:    if (push) state_d = RUN;
        RUN:     if (issue && !push && occupancy == OCC_W'(1)) state_d = IDLE;
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // An illegal return at full credits saturates instead of wrapping.
    case ({issue, rd_credit_ret})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   if (credits_q != CRED_W'(RD_CREDITS)) credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      credits_q <= CRED_W'(RD_CREDITS);
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
    end
  end

  assign credits = credits_q;

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rd_credit_ret && !issue && credits_q == CRED_W'(RD_CREDITS)))
        else $error("decode_issue_ctl: credit return overflows RD_CREDITS");
      assert (!(issue && credits_q == '0))
        else $error("decode_issue_ctl: issue with zero credits");
      if (issue) begin
        $display("INFO decode_issue_ctl: issue instr=%h credits=%0d occupancy=%0d",
                 head, credits_q, occupancy);
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_issue_ctl.sv
// Directed bench for decode_issue_ctl: a queue-based reference model checked
// every cycle, plus hand-computed expectations at the key scenario points.
module tb_decode_issue_ctl;
  import instr::*;

  localparam int DEPTH      = 4;
  localparam int RD_CREDITS = 4;

  logic                          clk;
  logic                          reset;
  logic                          fe_valid;
  t_rv_instr                     fe_instr;
  logic                          fe_ready;
  logic                          valid_de0;
  t_rv_instr                     instr_de0;
  logic                          rd_credit_ret;
  logic                          flush;
  logic [$clog2(DEPTH):0]        occupancy;
  logic [$clog2(RD_CREDITS):0]   credits;

  int n_checks = 0;
  int n_fails  = 0;

  decode_issue_ctl #(
    .DEPTH      (DEPTH),
    .RD_CREDITS (RD_CREDITS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fe_valid      (fe_valid),
    .fe_instr      (fe_instr),
    .fe_ready      (fe_ready),
    .valid_de0     (valid_de0),
    .instr_de0     (instr_de0),
    .rd_credit_ret (rd_credit_ret),
    .flush         (flush),
    .occupancy     (occupancy),
    .credits       (credits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic t_rv_instr make_instr(input int id);
    t_rv_instr r;
    r      = '0;
    r.bits = 32'h0000_0013 | (32'(id) << 7);
`ifdef SIMULATION
    r.simid = 16'(id);
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input int id,
                               input bit ret, input bit fl);
    @(posedge clk);
    #1;
    reset         = rst;
    fe_valid      = v;
    fe_instr      = v ? make_instr(id) : '0;
    rd_credit_ret = ret;
    flush         = fl;
  endtask

  task automatic step(input bit v, input int id, input bit ret, input bit fl);
    applyStimulus(1'b0, v, id, ret, fl);
  endtask

  // Reference model: queue contents, available credits, flush-bubble flag.
  t_rv_instr model_q[$];
  int        m_credits  = RD_CREDITS;
  bit        m_flushing = 1'b0;
  bit        exp_issue;
  bit        exp_ready;
  bit        m_push;
  t_rv_instr exp_instr;

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("reset_no_issue", 64'(valid_de0), 64'(0));
      checkOutput("reset_instr_zero", 64'(instr_de0), 64'(0));
      model_q.delete();
      m_credits  = RD_CREDITS;
      m_flushing = 1'b0;
    end else begin
      exp_ready = (model_q.size() < DEPTH) && !m_flushing;
      exp_issue = !m_flushing && (model_q.size() > 0) && (m_credits > 0) && !flush;
      exp_instr = exp_issue ? model_q[0] : '0;
      checkOutput("model_fe_ready", 64'(fe_ready), 64'(exp_ready));
      checkOutput("model_valid_de0", 64'(valid_de0), 64'(exp_issue));
      checkOutput("model_instr_de0", 64'(instr_de0), 64'(exp_instr));
      checkOutput("model_occupancy", 64'(occupancy), 64'(model_q.size()));
      checkOutput("model_credits", 64'(credits), 64'(m_credits));
      if (flush) begin
        model_q.delete();
        m_flushing = 1'b1;
      end else begin
        m_push = fe_valid && exp_ready;
        if (exp_issue) void'(model_q.pop_front());
        if (m_push) model_q.push_back(fe_instr);
        m_flushing = 1'b0;
      end
      if (exp_issue && !rd_credit_ret) m_credits--;
      else if (!exp_issue && rd_credit_ret && m_credits < RD_CREDITS) m_credits++;
    end
  end

  initial begin
    reset         = 1'b1;
    fe_valid      = 1'b0;
    fe_instr      = '0;
    rd_credit_ret = 1'b0;
    flush         = 1'b0;

    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Back-to-back A,B,C with full credits.
    step(1'b1, 1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_credits", 64'(credits), 64'(4));
    checkOutput("rst_occupancy", 64'(occupancy), 64'(0));
    checkOutput("rst_fe_ready", 64'(fe_ready), 64'(1));
    checkOutput("rst_valid", 64'(valid_de0), 64'(0));
    step(1'b1, 2, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abc_first_valid", 64'(valid_de0), 64'(1));
    checkOutput("abc_first_instr", 64'(instr_de0), 64'(make_instr(1)));
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abc_third_instr", 64'(instr_de0), 64'(make_instr(3)));
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abc_credits_after", 64'(credits), 64'(1));
    checkOutput("abc_occ_after", 64'(occupancy), 64'(0));

    // Credit starvation, fill to full, then a single credit return.
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b1, 101 + k, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("starve_no_issue", 64'(valid_de0), 64'(0));
    checkOutput("starve_credits", 64'(credits), 64'(0));
    step(1'b1, 107, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("starve_occ2", 64'(occupancy), 64'(2));
    checkOutput("starve_ready", 64'(fe_ready), 64'(1));
    step(1'b1, 108, 1'b0, 1'b0);
    step(1'b1, 109, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_occ", 64'(occupancy), 64'(4));
    checkOutput("full_not_ready", 64'(fe_ready), 64'(0));
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ret_issue_instr", 64'(instr_de0), 64'(make_instr(105)));
    checkOutput("ret_still_full", 64'(fe_ready), 64'(0));
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ret_ready_again", 64'(fe_ready), 64'(1));
    checkOutput("ret_occ3", 64'(occupancy), 64'(3));

    // Flush at occupancy 3 while fetch keeps pushing.
    step(1'b1, 110, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 111, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush_no_issue", 64'(valid_de0), 64'(0));
    checkOutput("flush_occ3", 64'(occupancy), 64'(3));
    step(1'b1, 112, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flushst_occ0", 64'(occupancy), 64'(0));
    checkOutput("flushst_not_ready", 64'(fe_ready), 64'(0));
    checkOutput("flushst_credits", 64'(credits), 64'(1));
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("postflush_ready", 64'(fe_ready), 64'(1));
    checkOutput("postflush_credits", 64'(credits), 64'(1));

    // Issue and credit return together at credits=1.
    step(1'b1, 201, 1'b0, 1'b0);
    for (int k = 1; k < 5; k++) step(1'b1, 201 + k, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pair_credits", 64'(credits), 64'(1));
    checkOutput("pair_occ", 64'(occupancy), 64'(0));

    // Reset mid-stream with a pending head, fetch and flush active.
    step(1'b1, 301, 1'b0, 1'b0);
    step(1'b1, 302, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 303, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("midrst_no_issue", 64'(valid_de0), 64'(0));
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midrst_occ", 64'(occupancy), 64'(0));
    checkOutput("midrst_credits", 64'(credits), 64'(4));
    checkOutput("midrst_ready", 64'(fe_ready), 64'(1));

    // Flush held for two cycles re-enters the bubble.
    step(1'b1, 401, 1'b0, 1'b0);
    step(1'b1, 402, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reflush_not_ready", 64'(fe_ready), 64'(0));
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reflush_ready", 64'(fe_ready), 64'(1));
    step(1'b0, 0, 1'b1, 1'b0);

    // Nine pushes through four entries with steady credit returns.
    step(1'b1, 500, 1'b0, 1'b0);
    step(1'b1, 501, 1'b0, 1'b0);
    for (int k = 2; k < 9; k++) begin
      step(1'b1, 500 + k, 1'b1, 1'b0);
      if (k == 5) begin
        @(negedge clk);
        checkOutput("wrap_mid_instr", 64'(instr_de0), 64'(make_instr(504)));
      end
    end
    step(1'b0, 0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("wrap_last_instr", 64'(instr_de0), 64'(make_instr(508)));
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("wrap_credits", 64'(credits), 64'(4));
    checkOutput("wrap_occ", 64'(occupancy), 64'(0));

    step(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
